// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetchState_t : fetch control states (RST, RUN, FLUSH)
//   fetchEntry_t : one buffered instruction word plus its fetch address
//   alignWord()  : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetchEntry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched words with their PCs.
// Ports:
//   Clk, Reset      : clock, synchronous active-low reset
//   flush           : drop all entries (wins over push/pop)
//   push, pushData  : write one entry
//   pop             : consume the head entry (ignored when empty)
//   head, headValid : registered head entry and its valid flag
//   count           : current occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetchEntry_t              pushData,
  input  logic                     pop,
  output fetchEntry_t              head,
  output logic                     headValid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetchEntry_t       mem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtrNext;
  logic [CNT_W-1:0]  countNext;
  logic              doPop;
  fetchEntry_t       headNext;

  // Next-state of pointers/count and the entry that will sit at the head.
  always_comb begin
    doPop     = pop && (count != '0);
    rdPtrNext = doPop ? rdPtr + PTR_W'(1) : rdPtr;
    countNext = count + CNT_W'(push) - CNT_W'(doPop);
    // A word pushed into the slot that becomes head bypasses the array.
    headNext  = (push && (wrPtr == rdPtrNext)) ? pushData : mem[rdPtrNext];
  end

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge Clk) begin
    if (Reset && !flush && push) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      headValid <= 1'b0;
      head      <= '0;
    end else if (flush) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      headValid <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      rdPtr     <= rdPtrNext;
      count     <= countNext;
      headValid <= (countNext != '0);
      if (countNext != '0) begin
        head <= headNext;
      end
    end
  end

  // The requester never lets occupancy plus in-flight exceed DEPTH.
  noPushWhenFull: assert property (@(posedge Clk) disable iff (!Reset)
    !(push && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one-word reads to
// instruction memory and buffers returned words for decode.
// Ports:
//   Clk, Reset          : clock, synchronous active-low reset
//   Redirect/_PC        : load new fetch PC and flush everything in flight
//   Imem_Req/_Addr      : memory read request (combinational)
//   Imem_RdData         : read data, one cycle after an accepted request
//   Instr/_PC/_Valid    : registered head instruction towards decode
//   Instr_Ready         : decode accepts the head this cycle
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_PC,
  output logic            Imem_Req,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic [XLEN-1:0] Imem_RdData,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] Instr_PC,
  output logic            Instr_Valid,
  input  logic            Instr_Ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetchState_t      state;
  fetchState_t      stateNext;
  logic [XLEN-1:0]  fpc;
  logic             inFlight;
  logic [XLEN-1:0]  inFlightPc;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   pending;
  logic             pop;
  logic             push;
  logic             redirectTake;
  fetchEntry_t      headEntry;
  fetchEntry_t      pushEntry;

  assign pop     = Instr_Valid & Instr_Ready;
  // Slots that will be committed after this edge if nothing new is requested.
  assign pending = (CNT_W+1)'(occ) + (CNT_W+1)'(inFlight) - (CNT_W+1)'(pop);
  // A redirect kills the response arriving this cycle.
  assign push    = inFlight & ~redirectTake;

  assign pushEntry = '{instr: Imem_RdData, pc: inFlightPc};

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= RST;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and memory request.
  always_comb begin
    stateNext    = state;
    Imem_Req     = 1'b0;
    Imem_Addr    = '0;
    redirectTake = 1'b0;
    case (state)
      RST: begin
        stateNext = RUN;
      end
      RUN: begin
        if (Redirect) begin
          redirectTake = 1'b1;
          stateNext    = FLUSH;
        end else if (pending < (CNT_W+1)'(DEPTH)) begin
          Imem_Req  = 1'b1;
          Imem_Addr = fpc;
        end
      end
      FLUSH: begin
        if (Redirect) begin
          redirectTake = 1'b1;
          stateNext    = FLUSH;
        end else begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RST;
      end
    endcase
  end

  // Fetch PC and the single outstanding response tracker.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fpc        <= alignWord(PC_RESET);
      inFlight   <= 1'b0;
      inFlightPc <= '0;
    end else begin
      inFlight <= Imem_Req;
      if (redirectTake) begin
        fpc <= alignWord(Redirect_PC);
      end else if (Imem_Req) begin
        fpc        <= fpc + XLEN'(WORD_BYTES);
        inFlightPc <= fpc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (redirectTake),
    .push      (push),
    .pushData  (pushEntry),
    .pop       (pop),
    .head      (headEntry),
    .headValid (Instr_Valid),
    .count     (occ)
  );

  assign Instr    = headEntry.instr;
  assign Instr_PC = headEntry.pc;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the processor's datapath/control pair: owns the fetch program counter, issues word reads to instruction memory and buffers returned words in a small FIFO. It presents instructions to the decode/control stage over a valid/ready handshake and accepts redirects (taken branches, jumps) from the datapath. Replaces the implicit single-cycle PC fetch so the core can stall without losing fetched words.

## Interface
- PC_RESET, 32'h0000_0000, fetch address after reset (word-aligned)
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-low; sampled only on Clk rising edge
- Redirect  in  1  load new fetch PC, flush everything in flight
- Redirect_PC  in  32  new fetch address; bits [1:0] ignored (forced 00)
- Imem_Req  out  1  read request this cycle
- Imem_Addr  out  32  word-aligned read address, valid when Imem_Req=1
- Imem_RdData  in  32  read data, valid exactly one cycle after the accepted request
- Instr  out  32  head instruction
- Instr_PC  out  32  address of Instr
- Instr_Valid  out  1  Instr/Instr_PC valid
- Instr_Ready  in  1  consumer accepts head this cycle

## Operation
- State machine: RST (Reset low), RUN, FLUSH.
- RST: FPC←PC_RESET, FIFO empty, in-flight cleared; all outputs 0. Reset high at edge → RUN.
- RUN: Imem_Req=1, Imem_Addr=FPC when occ + inflight − pop < DEPTH (pop = Instr_Valid & Instr_Ready); on request FPC←FPC+4 (32-bit, wraps 32'hFFFF_FFFC→0).
- Response: one cycle after a request, Imem_RdData pushed with its address into FIFO unless killed.
- Redirect (any state except RST): FIFO emptied, pending response marked killed and discarded, FPC←{Redirect_PC[31:2],2'b00}, go FLUSH; Imem_Req=0 that cycle. A pop in the same cycle is still a valid acceptance by the consumer.
- FLUSH: one bubble cycle, Imem_Req=0, Instr_Valid=0; → RUN. Redirect in FLUSH restarts FLUSH with new PC.
- Priority: Reset > Redirect > push/pop. Push and pop in the same cycle keep occ unchanged; push to a full FIFO cannot occur by construction (assertion).
- Instr/Instr_PC held stable while Instr_Valid=1 and Instr_Ready=0.
- Reset mid-operation: in-flight response discarded; no push after Reset.

## Timing
- First request: cycle after first edge with Reset high; Addr=PC_RESET.
- Fetch-to-valid latency: Instr_Valid rises 2 edges after the request edge (1 memory + 1 FIFO write).
- Redirect-to-valid: redirect edge → FLUSH → request → data → valid = Instr_Valid at 4th edge after Redirect.
- Steady throughput with Instr_Ready=1: one instruction per cycle, consecutive PCs +4.
- Consumer stall: requests stop once occ+inflight=DEPTH; resume the cycle Instr_Ready pops.
- Outputs are registered except Imem_Req/Imem_Addr (from state, counters, Redirect).

## Structure
- Package fetch_pkg: state enum (RST, RUN, FLUSH), PC_RESET default, WORD_BYTES=4, XLEN=32.
- Sub-module fetch_fifo: DEPTH×64 (instr+PC) synchronous FIFO with push/pop/flush, count output, same Clk/Reset.
- Top holds FPC, in-flight/kill flag, FSM.

## Test plan
- Reset low 3 cycles then high, Instr_Ready=1, memory word=addr^32'hA5A5_0000 -> Instr_PC 0,4,8,… one per cycle, first Instr_Valid 2 edges after first Imem_Req, Instr=32'hA5A5_0000.
- Instr_Ready=0 for 5 cycles after first valid -> exactly DEPTH=2 requests outstanding, Instr/Instr_PC=0 held; release -> PC 4 then 8 without gaps or duplicates.
- Redirect=1, Redirect_PC=32'h0000_0103 while one word in flight -> in-flight word dropped, next Instr_PC=32'h0000_0100, Instr_Valid 4 edges after redirect.
- Redirect and Instr_Ready pop in same cycle -> popped instruction counted once, no further old-path instruction appears.
- PC_RESET=32'hFFFF_FFF8 -> Instr_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset low mid-stream with one request in flight -> all outputs 0 next edge, no stale push after Reset returns high; fetch restarts at PC_RESET.
